// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter feeding an 8:1 word mux into a valid/ready output register.
// Optional burst locking is enabled by defining MUX8_ARB_LOCK_EN.

module testmux8 #(
  parameter int unsigned N = 64
) (
  input  logic [2:0]   s,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [N-1:0] d4,
  input  logic [N-1:0] d5,
  input  logic [N-1:0] d6,
  input  logic [N-1:0] d7,
  output logic [N-1:0] y
);
  always_comb begin
    unique case (s)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      3'd5: y = d5;
      3'd6: y = d6;
      default: y = d7;
    endcase
  end
endmodule

module mux8_rr_arbiter #(
  parameter int unsigned N         = 64,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   req,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [N-1:0] d4,
  input  logic [N-1:0] d5,
  input  logic [N-1:0] d6,
  input  logic [N-1:0] d7,
`ifdef MUX8_ARB_LOCK_EN
  input  logic [7:0]   lock,
`endif
  output logic [7:0]   grant,
  output logic [2:0]   s,
  output logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int unsigned CNT_W = 4;

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
    $error("BURST_MAX out of range 1..15");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state, state_nxt;
  logic [2:0]   ptr;
  logic [2:0]   s_nxt;
  logic         found;
  logic         cap;
  logic         any_req;
  logic [N-1:0] mux_y;
`ifdef MUX8_ARB_LOCK_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
`endif

  assign any_req   = |req;
  assign out_valid = (state == FULL);
  assign cap       = any_req && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (cap) state_nxt = FULL;
      FULL:    if (out_ready && !any_req) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Winner scan from ptr upward with wrap; also drives the one-hot grant.
  always_comb begin
    s_nxt = ptr;
    found = 1'b0;
    grant = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[3'(ptr + 3'(i))]) begin
        s_nxt = 3'(ptr + 3'(i));
        found = 1'b1;
      end
    end
    if (cap && !reset) grant[s_nxt] = 1'b1;
  end

`ifdef MUX8_ARB_LOCK_EN
  // Burst length restarts whenever the winner differs from the last captured index.
  always_comb begin
    cnt_inc = CNT_W'(((s_nxt == s) ? cnt : CNT_W'(0)) + CNT_W'(1));
  end
`endif

  testmux8 #(.N(N)) u_mux (
    .s (s_nxt),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      y   <= '0;
      s   <= 3'd0;
      ptr <= 3'd0;
`ifdef MUX8_ARB_LOCK_EN
      cnt <= '0;
`endif
    end else if (cap) begin
      y <= mux_y;
      s <= s_nxt;
`ifdef MUX8_ARB_LOCK_EN
      if (lock[s_nxt] && (cnt_inc < CNT_W'(BURST_MAX))) begin
        ptr <= s_nxt;
        cnt <= cnt_inc;
      end else begin
        ptr <= 3'(s_nxt + 3'd1);
        cnt <= '0;
      end
`else
      ptr <= 3'(s_nxt + 3'd1);
`endif
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter; expected output words go through a scoreboard queue.
`timescale 1ns/1ps

module tb_mux8_rr_arbiter;
  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req;
  logic [N-1:0] dv [8];
  logic [7:0]   grant;
  logic [2:0]   s;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
`ifdef MUX8_ARB_LOCK_EN
  logic [7:0]   lock = 8'd0;
`endif

  int checks = 0;
  int errors = 0;
  logic [N+2:0] sb [$];

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.N(N), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .d4(dv[4]), .d5(dv[5]), .d6(dv[6]), .d7(dv[7]),
`ifdef MUX8_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .s(s), .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Monitor: a word handed over at the next edge is compared against the queue head.
  always @(negedge clk) begin
    logic [N+2:0] e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected s=%0d y=%0d (queue empty)", s, y);
      end else begin
        e = sb.pop_front();
        if ({s, y} !== e) begin
          errors++;
          $display("FAIL word s=%0d y=%0d expected s=%0d y=%0d", s, y, e[N+2:N], e[N-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check grant mid-cycle, push the expected captured word.
  task automatic cyc(input logic [7:0] r, input logic rdy, input logic [7:0] exp_grant);
    int win;
    req = r;
    out_ready = rdy;
    @(negedge clk);
    check("grant", N'(grant), N'(exp_grant));
    win = -1;
    for (int i = 0; i < 8; i++) if (exp_grant[i]) win = i;
    if (win >= 0) sb.push_back({3'(win), dv[win]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) dv[k] = N'(k + 10);
    reset = 1'b1;
    req = 8'hFF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_grant", N'(grant), '0);
    check("rst_valid", N'(out_valid), '0);
    check("rst_y", y, '0);
    check("rst_s", N'(s), '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Rotation across all requesters, then wrap back to 0.
    for (int k = 0; k < 8; k++) cyc(8'hFF, 1'b1, 8'(1 << k));
    cyc(8'hFF, 1'b1, 8'h01);
    cyc(8'h00, 1'b1, 8'h00);
    check("drain_valid", N'(out_valid), '0);

    reset = 1'b1; req = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;

    // Sparse requesters with wrap from 7 to 0.
    cyc(8'h84, 1'b1, 8'h04);
    cyc(8'h84, 1'b1, 8'h80);
    cyc(8'h85, 1'b1, 8'h01);
    cyc(8'h84, 1'b1, 8'h04);
    cyc(8'h84, 1'b1, 8'h80);
    cyc(8'h84, 1'b1, 8'h04);
    cyc(8'h00, 1'b1, 8'h00);

    // Stall holds the word and suppresses grants.
    dv[3] = N'(5);
    cyc(8'h08, 1'b1, 8'h08);
    for (int k = 0; k < 3; k++) begin
      cyc(8'h08, 1'b0, 8'h00);
      check("stall_y", y, N'(5));
      check("stall_valid", N'(out_valid), N'(1));
    end
    cyc(8'h08, 1'b1, 8'h08);
    cyc(8'h00, 1'b0, 8'h00);
    check("held_valid", N'(out_valid), N'(1));

    // Reset mid-stall discards the held word.
    reset = 1'b1;
    void'(sb.pop_front());
    @(negedge clk);
    check("rstmid_grant", N'(grant), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_valid", N'(out_valid), '0);
    check("rstmid_y", y, '0);
    cyc(8'h00, 1'b1, 8'h00);
    check("rstmid_valid2", N'(out_valid), '0);

`ifdef MUX8_ARB_LOCK_EN
    lock = 8'h01;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) cyc(8'h03, 1'b1, 8'h01);
      cyc(8'h03, 1'b1, 8'h02);
    end
    lock = 8'h00;
    cyc(8'h00, 1'b1, 8'h00);
`endif

    repeat (2) @(posedge clk);
    check("sb_empty", N'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
